// File: rtl/cmult_share_arbiter_if.sv
// cmult_share_arbiter_if
// Bundles the request, shared-multiplier and result signals of cmult_share_arbiter.
//   req_valid/req_ready      per-requester handshake (ready is a one-hot grant)
//   req_a_*/req_b_*          packed operands, requester k in bits [16k+15:16k]
//   mult_a_*/mult_b_*        operands presented to the shared multiplier
//   mult_strobe              operands on mult_* are valid this cycle
//   mult_p_*                 multiplier product, returned MULT_LATENCY cycles later
//   res_p_*/res_strobe       returned product and its one-hot owner
// slave  : the arbiter's view
// master : the surrounding datapath's view (requesters and multiplier)
interface cmult_share_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a_i;
    logic [16*NUM_REQ-1:0] req_a_q;
    logic [16*NUM_REQ-1:0] req_b_i;
    logic [16*NUM_REQ-1:0] req_b_q;
    logic [15:0]           mult_a_i;
    logic [15:0]           mult_a_q;
    logic [15:0]           mult_b_i;
    logic [15:0]           mult_b_q;
    logic                  mult_strobe;
    logic [31:0]           mult_p_i;
    logic [31:0]           mult_p_q;
    logic [31:0]           res_p_i;
    logic [31:0]           res_p_q;
    logic [NUM_REQ-1:0]    res_strobe;

    modport slave (
        input  req_valid, req_a_i, req_a_q, req_b_i, req_b_q, mult_p_i, mult_p_q,
        output req_ready, mult_a_i, mult_a_q, mult_b_i, mult_b_q, mult_strobe,
        output res_p_i, res_p_q, res_strobe
    );

    modport master (
        output req_valid, req_a_i, req_a_q, req_b_i, req_b_q, mult_p_i, mult_p_q,
        input  req_ready, mult_a_i, mult_a_q, mult_b_i, mult_b_q, mult_strobe,
        input  res_p_i, res_p_q, res_strobe
    );
endinterface

// File: rtl/cmult_share_arbiter.sv
// cmult_share_arbiter
// Shares one pipelined complex multiplier between NUM_REQ requesters with
// round-robin arbitration, and routes each product back to its originator
// through a tag pipeline that tracks the multiplier latency.
// Ports:
//   clock   single clock, all logic on posedge
//   reset   synchronous, active-high
//   enable  low blocks new grants; products already issued still return
//   busy    high while any issued product has not yet been returned
//   bus     request / multiplier / result signals (cmult_share_arbiter_if.slave)
module cmult_share_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int MULT_LATENCY = 4,
    parameter int IDX_W        = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 busy,
    cmult_share_arbiter_if.slave bus
);
    localparam int STAGES = MULT_LATENCY + 1;
    localparam int CNT_W  = $clog2(MULT_LATENCY + 3);

    logic [IDX_W-1:0]   lastGrant_q;
    logic [IDX_W-1:0]   grantIdx;
    logic [IDX_W-1:0]   candIdx;
    logic [NUM_REQ-1:0] grant;
    logic               accept;

    logic               tagValid_q [STAGES];
    logic [IDX_W-1:0]   tagIdx_q   [STAGES];

    logic [15:0]        multAReal_q;
    logic [15:0]        multAImag_q;
    logic [15:0]        multBReal_q;
    logic [15:0]        multBImag_q;
    logic               multStrobe_q;
    logic [31:0]        resReal_q;
    logic [31:0]        resImag_q;
    logic [NUM_REQ-1:0] resStrobe_q;
    logic [CNT_W-1:0]   inFlight_q;
    logic [CNT_W-1:0]   inFlight_d;
    logic               busy_q;

    // Round-robin search starting just after the last granted requester.
    // A requester that holds valid is reached within NUM_REQ grants, so
    // nobody starves under continuous contention.
    always_comb begin
        grant    = '0;
        grantIdx = lastGrant_q;
        candIdx  = lastGrant_q;
        accept   = 1'b0;
        if (enable && !reset) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                candIdx = IDX_W'((int'(lastGrant_q) + i) % NUM_REQ);
                if (!accept && bus.req_valid[candIdx]) begin
                    accept   = 1'b1;
                    grantIdx = candIdx;
                end
            end
        end
        if (accept) begin
            grant[grantIdx] = 1'b1;
        end
    end

    assign bus.req_ready = grant;

    // Outstanding-product count: an accept and a returned result in the
    // same cycle cancel out.
    always_comb begin
        inFlight_d = inFlight_q;
        if (accept && !(|resStrobe_q)) begin
            inFlight_d = inFlight_q + 1'b1;
        end else if (!accept && (|resStrobe_q)) begin
            inFlight_d = inFlight_q - 1'b1;
        end
    end

    // Issue, tag tracking and result return. The tag pipeline shifts every
    // cycle regardless of enable so issued products always come back; it is
    // one stage longer than the multiplier so the last stage lines up with
    // the product on mult_p_*.
    always_ff @(posedge clock) begin
        if (reset) begin
            lastGrant_q  <= IDX_W'(NUM_REQ - 1);
            multAReal_q  <= '0;
            multAImag_q  <= '0;
            multBReal_q  <= '0;
            multBImag_q  <= '0;
            multStrobe_q <= 1'b0;
            resReal_q    <= '0;
            resImag_q    <= '0;
            resStrobe_q  <= '0;
            inFlight_q   <= '0;
            busy_q       <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                tagValid_q[s] <= 1'b0;
                tagIdx_q[s]   <= '0;
            end
        end else begin
            tagValid_q[0] <= accept;
            tagIdx_q[0]   <= grantIdx;
            for (int s = 1; s < STAGES; s++) begin
                tagValid_q[s] <= tagValid_q[s-1];
                tagIdx_q[s]   <= tagIdx_q[s-1];
            end

            multStrobe_q <= accept;
            if (accept) begin
                lastGrant_q <= grantIdx;
                multAReal_q <= bus.req_a_i[16*grantIdx +: 16];
                multAImag_q <= bus.req_a_q[16*grantIdx +: 16];
                multBReal_q <= bus.req_b_i[16*grantIdx +: 16];
                multBImag_q <= bus.req_b_q[16*grantIdx +: 16];
            end

            if (tagValid_q[STAGES-1]) begin
                resReal_q   <= bus.mult_p_i;
                resImag_q   <= bus.mult_p_q;
                resStrobe_q <= NUM_REQ'(1) << tagIdx_q[STAGES-1];
            end else begin
                resStrobe_q <= '0;
            end

            inFlight_q <= inFlight_d;
            busy_q     <= (inFlight_d != '0);
        end
    end

    assign bus.mult_a_i    = multAReal_q;
    assign bus.mult_a_q    = multAImag_q;
    assign bus.mult_b_i    = multBReal_q;
    assign bus.mult_b_q    = multBImag_q;
    assign bus.mult_strobe = multStrobe_q;
    assign bus.res_p_i     = resReal_q;
    assign bus.res_p_q     = resImag_q;
    assign bus.res_strobe  = resStrobe_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_cmult_share_arbiter.sv
// tb_cmult_share_arbiter
// Drives cmult_share_arbiter with directed scenarios followed by random traffic.
// A behavioural multiplier with MULT_LATENCY stages closes the loop; a
// scoreboard of expected results (owner, due cycle, product) predicts every
// output cycle by cycle.
module tb_cmult_share_arbiter;
    localparam int NUM_REQ = 2;
    localparam int L       = 4;
    localparam int IDX_W   = 1;

    logic clock = 1'b0;
    logic reset;
    logic enable;
    logic busy;

    always #5 clock = ~clock;

    cmult_share_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

    cmult_share_arbiter #(
        .NUM_REQ(NUM_REQ),
        .MULT_LATENCY(L),
        .IDX_W(IDX_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .busy(busy),
        .bus(bus)
    );

    // Behavioural pipelined complex multiplier: product of the operands seen
    // in cycle c appears on mult_p_* in cycle c+L.
    logic signed [31:0] pipeI [L];
    logic signed [31:0] pipeQ [L];

    always @(posedge clock) begin
        pipeI[0] <= $signed(bus.mult_a_i) * $signed(bus.mult_b_i) - $signed(bus.mult_a_q) * $signed(bus.mult_b_q);
        pipeQ[0] <= $signed(bus.mult_a_i) * $signed(bus.mult_b_q) + $signed(bus.mult_a_q) * $signed(bus.mult_b_i);
        for (int i = 1; i < L; i++) begin
            pipeI[i] <= pipeI[i-1];
            pipeQ[i] <= pipeQ[i-1];
        end
    end

    assign bus.mult_p_i = pipeI[L-1];
    assign bus.mult_p_q = pipeQ[L-1];

    typedef struct {
        int          idx;
        int          due;
        logic [31:0] pi;
        logic [31:0] pq;
    } exp_t;

    exp_t               sb[$];
    logic [NUM_REQ-1:0] vld;
    logic [15:0]        ai [NUM_REQ];
    logic [15:0]        aq [NUM_REQ];
    logic [15:0]        bi [NUM_REQ];
    logic [15:0]        bq [NUM_REQ];
    int                 lastG;
    int                 lastDue;
    int                 cyc;
    bit                 modelOk;
    logic               expMStrobe;
    logic [63:0]        expOps;
    logic [31:0]        expResI;
    logic [31:0]        expResQ;
    int                 total;
    int                 bad;

    // Reference complex product with plain integer arithmetic.
    function automatic logic [63:0] cmul(input logic [15:0] a_i, input logic [15:0] a_q,
                                         input logic [15:0] b_i, input logic [15:0] b_q);
        int ar;
        int ac;
        int br;
        int bc;
        int re;
        int im;
        ar = int'($signed(a_i));
        ac = int'($signed(a_q));
        br = int'($signed(b_i));
        bc = int'($signed(b_q));
        re = ar * br - ac * bc;
        im = ar * bc + ac * br;
        return {re, im};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic driveBus();
        bus.req_valid = vld;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_a_i[16*k +: 16] = ai[k];
            bus.req_a_q[16*k +: 16] = aq[k];
            bus.req_b_i[16*k +: 16] = bi[k];
            bus.req_b_q[16*k +: 16] = bq[k];
        end
    endtask

    task automatic raise(input int k, input logic [15:0] a_i, input logic [15:0] a_q,
                         input logic [15:0] b_i, input logic [15:0] b_q);
        vld[k] = 1'b1;
        ai[k]  = a_i;
        aq[k]  = a_q;
        bi[k]  = b_i;
        bq[k]  = b_q;
    endtask

    // Requesters may only load new operands once their previous one was taken.
    task automatic refill(input int pct);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!vld[k] && ($urandom_range(99) < pct)) begin
                raise(k, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            end
        end
    endtask

    // One clock cycle: drive inputs, check every output against the model,
    // then advance the model across the edge.
    task automatic applyStimulus();
        int                 g;
        int                 c;
        logic [NUM_REQ-1:0] expReady;
        logic [NUM_REQ-1:0] expRS;
        driveBus();
        #1;
        g = -1;
        if (enable && !reset) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                c = (lastG + i) % NUM_REQ;
                if (g < 0 && vld[c]) g = c;
            end
        end
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        checkOutput("req_ready", 64'(bus.req_ready), 64'(expReady));

        if (modelOk) begin
            checkOutput("mult_strobe", 64'(bus.mult_strobe), 64'(expMStrobe));
            checkOutput("mult_ops", {bus.mult_a_i, bus.mult_a_q, bus.mult_b_i, bus.mult_b_q}, expOps);
            expRS = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                expRS[sb[0].idx] = 1'b1;
                expResI = sb[0].pi;
                expResQ = sb[0].pq;
                void'(sb.pop_front());
            end
            checkOutput("res_strobe", 64'(bus.res_strobe), 64'(expRS));
            checkOutput("res_p", {bus.res_p_i, bus.res_p_q}, {expResI, expResQ});
            checkOutput("busy", 64'(busy), 64'(lastDue >= cyc));
        end

        if (reset) begin
            sb.delete();
            lastDue    = -1;
            lastG      = NUM_REQ - 1;
            expMStrobe = 1'b0;
            expOps     = '0;
            expResI    = '0;
            expResQ    = '0;
            modelOk    = 1'b1;
        end else begin
            expMStrobe = (g >= 0);
            if (g >= 0) begin
                exp_t e;
                logic [63:0] p;
                p      = cmul(ai[g], aq[g], bi[g], bq[g]);
                e.idx  = g;
                e.due  = cyc + L + 2;
                e.pi   = p[63:32];
                e.pq   = p[31:0];
                sb.push_back(e);
                lastDue = e.due;
                lastG   = g;
                expOps  = {ai[g], aq[g], bi[g], bq[g]};
                vld[g]  = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        modelOk = 1'b0;
        lastG   = NUM_REQ - 1;
        lastDue = -1;
        expMStrobe = 1'b0;
        expOps  = '0;
        expResI = '0;
        expResQ = '0;
        vld     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            ai[k] = '0; aq[k] = '0; bi[k] = '0; bq[k] = '0;
        end
        reset  = 1'b1;
        enable = 1'b1;
        driveBus();
        @(posedge clock);
        #1;

        // Reset and settle.
        idle(5);
        reset = 1'b0;
        idle(4);

        // Single request (3+4j)*(1+2j) = -5+10j.
        raise(0, 16'd3, 16'd4, 16'd1, 16'd2);
        idle(10);
        checkOutput("single_res_i", 64'(bus.res_p_i), 64'(32'hFFFF_FFFB));
        checkOutput("single_res_q", 64'(bus.res_p_q), 64'(32'd10));

        // Contention from a fresh reset: both requesters valid continuously.
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            refill(100);
            applyStimulus();
        end
        idle(8);

        // Enable low for 5 cycles with 3 products in flight.
        for (int i = 0; i < 3; i++) begin
            refill(100);
            applyStimulus();
        end
        enable = 1'b0;
        refill(100);
        idle(5);
        enable = 1'b1;
        idle(10);

        // Reset two cycles after an accept: the in-flight product is dropped.
        raise(1, 16'h1234, 16'h0042, 16'h7FFF, 16'h8001);
        applyStimulus();
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        idle(10);
        raise(0, 16'd7, 16'd0, 16'd5, 16'd0);
        raise(1, 16'd9, 16'd0, 16'd2, 16'd0);
        driveBus();
        #1;
        checkOutput("ptr_after_reset", 64'(bus.req_ready), 64'(2'b01));
        idle(12);

        // Extremes: (-32768)*(-32768) = 2^30.
        raise(0, 16'h8000, 16'h0000, 16'h8000, 16'h0000);
        idle(9);
        checkOutput("ext_res_i", 64'(bus.res_p_i), 64'(32'h4000_0000));
        checkOutput("ext_res_q", 64'(bus.res_p_q), 64'(32'h0000_0000));

        // Random traffic with occasional enable drops and resets.
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(9) != 0);
            reset  = ($urandom_range(79) == 0);
            refill(60);
            applyStimulus();
        end
        reset  = 1'b0;
        enable = 1'b1;
        vld    = '0;
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
